// File: rtl/hbridge_drive_sequencer_if.sv
// Bundle between the requesters (DirectionControl, CollisionDetection, ToneDetection, PWM) and the H-bridge owner.
// master drives requests and PWM; slave owns the bridge pins and reports owner/manoeuvre status.
interface hbridge_drive_sequencer_if;
   logic       lf_req;
   logic [1:0] lf_en;
   logic [3:0] lf_dir;
   logic       col_stop;
   logic       jnc_req;
   logic [2:0] jnc_cmd;
   logic       pwm_full;
   logic       pwm_slow;
   logic       pwm_fast;
   logic       hb_en_a;
   logic       hb_en_b;
   logic [3:0] hb_in;
   logic [1:0] owner;
   logic       jnc_busy;
   logic       jnc_done;
   logic       reverse;

   modport master (
      output lf_req, lf_en, lf_dir, col_stop, jnc_req, jnc_cmd, pwm_full, pwm_slow, pwm_fast,
      input  hb_en_a, hb_en_b, hb_in, owner, jnc_busy, jnc_done, reverse
   );

   modport slave (
      input  lf_req, lf_en, lf_dir, col_stop, jnc_req, jnc_cmd, pwm_full, pwm_slow, pwm_fast,
      output hb_en_a, hb_en_b, hb_in, owner, jnc_busy, jnc_done, reverse
   );
endinterface

// File: rtl/hbridge_drive_sequencer.sv
// Sole H-bridge owner: collision > junction manoeuvre > line follower, dead-time on pattern swaps.
// All outputs registered (1 cycle); collision freezes every counter and drops the enables.
module hbridge_drive_sequencer #(
   parameter int DEAD_CYCLES  = 50_000,
   parameter int CREEP_CYCLES = 2_500_000,
   parameter int TURN_CYCLES  = 25_000_000,
   parameter int CNT_W        = 27
) (
   input logic clk,
   input logic rst,
   hbridge_drive_sequencer_if.slave bus
);
   localparam int DW = $clog2(DEAD_CYCLES + 1);

   localparam logic [2:0] CMD_STRAIGHT = 3'b000;
   localparam logic [2:0] CMD_LEFT     = 3'b001;
   localparam logic [2:0] CMD_RIGHT    = 3'b010;
   localparam logic [2:0] CMD_BACK     = 3'b011;

   localparam logic [3:0] PAT_CREEP = 4'b0110;
   localparam logic [3:0] PAT_LEFT  = 4'b0101;
   localparam logic [3:0] PAT_RIGHT = 4'b1010;
   localparam logic [3:0] PAT_BACK  = 4'b1001;

   typedef enum logic [2:0] {IDLE, FOLLOW, CREEP, TURN, HOLD} state_t;

   state_t           state, nxtState;
   logic [2:0]       cmd, nxtCmd;
   logic [CNT_W-1:0] phaseCnt, nxtPhase;
   logic [DW-1:0]    deadCnt;
   logic [3:0]       deadTgt;
   logic [3:0]       hbIn;
   logic             hbEnA, hbEnB;
   logic [1:0]       owner;
   logic             jncBusy, jncDone, reverse;

   logic             running, finish, busyNxt, deadHold, deadStart;
   logic [3:0]       selPat;
   logic             selEnA, selEnB;

   function automatic state_t entryOf(input logic [2:0] c);
      if (c[2])
         return HOLD;
      else if (c == CMD_BACK)
         return TURN;
      else
         return CREEP;
   endfunction

   always_comb begin
      running  = (deadCnt == '0);
      nxtState = state;
      nxtCmd   = cmd;
      finish   = 1'b0;
      case (state)
         IDLE, FOLLOW: begin
            if (bus.jnc_req) begin
               nxtCmd   = bus.jnc_cmd;
               nxtState = entryOf(bus.jnc_cmd);
            end else begin
               nxtState = bus.lf_req ? FOLLOW : IDLE;
            end
         end
         HOLD: begin
            if (bus.jnc_req && !bus.jnc_cmd[2]) begin
               nxtCmd   = bus.jnc_cmd;
               nxtState = entryOf(bus.jnc_cmd);
            end
         end
         CREEP: begin
            if (running && phaseCnt == CNT_W'(CREEP_CYCLES - 1)) begin
               if (cmd == CMD_STRAIGHT)
                  finish = 1'b1;
               else
                  nxtState = TURN;
            end
         end
         TURN: begin
            if (running && phaseCnt == CNT_W'(TURN_CYCLES - 1))
               finish = 1'b1;
         end
         default: nxtState = IDLE;
      endcase
      if (finish)
         nxtState = bus.lf_req ? FOLLOW : IDLE;

      // Phase time only accrues while the manoeuvre pattern is actually on the bridge.
      if (nxtState != state)
         nxtPhase = '0;
      else if ((state == CREEP || state == TURN) && running)
         nxtPhase = phaseCnt + 1'b1;
      else
         nxtPhase = phaseCnt;

      busyNxt = (nxtState == CREEP) || (nxtState == TURN) || (nxtState == HOLD);

      selPat = 4'b0000;
      selEnA = 1'b0;
      selEnB = 1'b0;
      case (nxtState)
         FOLLOW: begin
            selPat = bus.lf_dir;
            selEnA = bus.lf_en[0];
            selEnB = bus.lf_en[1];
         end
         CREEP: begin
            selPat = PAT_CREEP;
            selEnA = bus.pwm_full;
            selEnB = bus.pwm_full;
         end
         TURN: begin
            case (nxtCmd)
               CMD_LEFT: begin
                  selPat = PAT_LEFT;
                  selEnA = bus.pwm_slow;
                  selEnB = bus.pwm_fast;
               end
               CMD_RIGHT: begin
                  selPat = PAT_RIGHT;
                  selEnA = bus.pwm_fast;
                  selEnB = bus.pwm_slow;
               end
               default: begin
                  selPat = PAT_BACK;
                  selEnA = bus.pwm_full;
                  selEnB = bus.pwm_full;
               end
            endcase
         end
         default: ;
      endcase

      // hbIn reads 0000 throughout dead-time, so the live comparison is against deadTgt then.
      deadHold  = !running && (selPat == deadTgt) && (deadCnt != DW'(1));
      deadStart = (selPat != 4'b0000) &&
                  ((!running && selPat != deadTgt) ||
                   (running && hbIn != 4'b0000 && selPat != hbIn));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cmd      <= 3'b000;
         phaseCnt <= '0;
         deadCnt  <= '0;
         deadTgt  <= 4'b0000;
         hbIn     <= 4'b0000;
         hbEnA    <= 1'b0;
         hbEnB    <= 1'b0;
         owner    <= 2'b00;
         jncBusy  <= 1'b0;
         jncDone  <= 1'b0;
         reverse  <= 1'b0;
      end else if (bus.col_stop) begin
         hbEnA   <= 1'b0;
         hbEnB   <= 1'b0;
         owner   <= 2'b11;
         jncDone <= 1'b0;
      end else begin
         state    <= nxtState;
         cmd      <= nxtCmd;
         phaseCnt <= nxtPhase;
         jncBusy  <= busyNxt;
         jncDone  <= finish;
         if (finish && cmd == CMD_BACK)
            reverse <= ~reverse;
         owner <= busyNxt ? 2'b10 : ((nxtState == FOLLOW) ? 2'b01 : 2'b00);

         if (deadStart) begin
            deadCnt <= DW'(DEAD_CYCLES);
            deadTgt <= selPat;
            hbIn    <= 4'b0000;
            hbEnA   <= 1'b0;
            hbEnB   <= 1'b0;
         end else if (deadHold) begin
            deadCnt <= deadCnt - 1'b1;
            hbIn    <= 4'b0000;
            hbEnA   <= 1'b0;
            hbEnB   <= 1'b0;
         end else begin
            deadCnt <= '0;
            hbIn    <= selPat;
            hbEnA   <= selEnA;
            hbEnB   <= selEnB;
         end
      end
   end

   assign bus.hb_en_a  = hbEnA;
   assign bus.hb_en_b  = hbEnB;
   assign bus.hb_in    = hbIn;
   assign bus.owner    = owner;
   assign bus.jnc_busy = jncBusy;
   assign bus.jnc_done = jncDone;
   assign bus.reverse  = reverse;
endmodule

// File: tb/tb_hbridge_drive_sequencer.sv
// Directed manoeuvre scenarios with randomized PWM / line-follower inputs, checked against
// per-phase expectations (pattern, enable source, owner, busy) derived from the manoeuvre timeline.
module tb_hbridge_drive_sequencer;
   localparam int DEAD  = 4;
   localparam int CREEP = 10;
   localparam int TURN  = 20;

   localparam int KOFF   = 0;
   localparam int KFULL  = 1;
   localparam int KLEFT  = 2;
   localparam int KRIGHT = 3;
   localparam int KLF    = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hbridge_drive_sequencer_if bus();

   hbridge_drive_sequencer #(
      .DEAD_CYCLES (DEAD),
      .CREEP_CYCLES(CREEP),
      .TURN_CYCLES (TURN),
      .CNT_W       (27)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;
   logic       pF, pS, pQ;
   logic [1:0] pEn;
   logic       expRev;
   logic [3:0] cur;

   // Randomize PWM and lf_en, then advance one clock; outputs are read 1 time unit after the edge.
   task automatic step();
      bus.pwm_full = 1'($urandom);
      bus.pwm_slow = 1'($urandom);
      bus.pwm_fast = 1'($urandom);
      bus.lf_en    = 2'($urandom);
      pF  = bus.pwm_full;
      pS  = bus.pwm_slow;
      pQ  = bus.pwm_fast;
      pEn = bus.lf_en;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] pat, input int kind,
                      input logic [1:0] own, input logic busy, input logic done);
      logic a, b;
      logic [10:0] expv, got;
      case (kind)
         KFULL:   begin a = pF;     b = pF;     end
         KLEFT:   begin a = pS;     b = pQ;     end
         KRIGHT:  begin a = pQ;     b = pS;     end
         KLF:     begin a = pEn[0]; b = pEn[1]; end
         default: begin a = 1'b0;   b = 1'b0;   end
      endcase
      expv = {a, b, pat, own, busy, done, expRev};
      got  = {bus.hb_en_a, bus.hb_en_b, bus.hb_in, bus.owner, bus.jnc_busy, bus.jnc_done, bus.reverse};
      checks++;
      assert (got === expv) else begin
         errors++;
         $error("FAIL %s observed={enA,enB,in,owner,busy,done,rev}=%b expected=%b", tag, got, expv);
      end
   endtask

   task automatic seg(input string tag, input int n, input logic [3:0] pat, input int kind,
                      input logic [1:0] own, input logic busy);
      for (int i = 0; i < n; i++) begin
         step();
         chk(tag, pat, kind, own, busy, 1'b0);
      end
   endtask

   task automatic doneStep(input string tag, input logic [3:0] pat, input int kind, input logic [1:0] own);
      step();
      chk(tag, pat, kind, own, 1'b0, 1'b1);
   endtask

   // Line follower swaps pattern; dead-time only between two differing nonzero patterns.
   task automatic toFollow(input logic [3:0] p, input int hold);
      bus.lf_dir = p;
      if (p != cur && p != 4'b0000 && cur != 4'b0000) begin
         seg("deadFollow", DEAD, 4'b0000, KOFF, 2'b01, 1'b0);
         seg("followNew", hold, p, KLF, 2'b01, 1'b0);
      end else begin
         seg("followKeep", hold, p, KLF, 2'b01, 1'b0);
      end
      cur = p;
   endtask

   // BACK manoeuvre from FOLLOW on 0110; optional collision after colAt turn cycles.
   task automatic runBack(input int colAt);
      bus.jnc_cmd = 3'b011;
      bus.jnc_req = 1'b1;
      seg("deadBack", 1, 4'b0000, KOFF, 2'b10, 1'b1);
      bus.jnc_req = 1'b0;
      seg("deadBack", DEAD - 1, 4'b0000, KOFF, 2'b10, 1'b1);
      if (colAt > 0) begin
         seg("turnBackPre", colAt, 4'b1001, KFULL, 2'b10, 1'b1);
         bus.col_stop = 1'b1;
         seg("colTurn", 7, 4'b1001, KOFF, 2'b11, 1'b1);
         bus.col_stop = 1'b0;
         seg("turnBackPost", TURN - colAt, 4'b1001, KFULL, 2'b10, 1'b1);
      end else begin
         seg("turnBack", TURN, 4'b1001, KFULL, 2'b10, 1'b1);
      end
      expRev = ~expRev;
      doneStep("doneBack", 4'b0000, KOFF, 2'b01);
      seg("deadAfterBack", DEAD - 1, 4'b0000, KOFF, 2'b01, 1'b0);
      seg("followAfterBack", 2, cur, KLF, 2'b01, 1'b0);
   endtask

   initial begin
      rst          = 1'b1;
      bus.lf_req   = 1'b0;
      bus.lf_dir   = 4'b0000;
      bus.col_stop = 1'b0;
      bus.jnc_req  = 1'b0;
      bus.jnc_cmd  = 3'b000;
      expRev       = 1'b0;
      cur          = 4'b0000;

      seg("reset", 3, 4'b0000, KOFF, 2'b00, 1'b0);

      // Line follower takes the bridge one cycle after the request.
      rst        = 1'b0;
      bus.lf_req = 1'b1;
      bus.lf_dir = 4'b0110;
      seg("follow", 4, 4'b0110, KLF, 2'b01, 1'b0);
      cur = 4'b0110;

      for (int i = 0; i < 16; i++) begin
         logic [3:0] p;
         p = 4'($urandom);
         if ($urandom_range(0, 3) == 0)
            p = cur;
         toFollow(p, 3);
      end

      // Dead counter restart on a further change, and early exit on a change to 0000.
      toFollow(4'b0110, 2);
      bus.lf_dir = 4'b1010;
      seg("deadA", 2, 4'b0000, KOFF, 2'b01, 1'b0);
      bus.lf_dir = 4'b0101;
      seg("deadRestart", DEAD, 4'b0000, KOFF, 2'b01, 1'b0);
      seg("afterRestart", 2, 4'b0101, KLF, 2'b01, 1'b0);
      bus.lf_dir = 4'b1010;
      seg("deadB", 2, 4'b0000, KOFF, 2'b01, 1'b0);
      bus.lf_dir = 4'b0000;
      seg("deadToZero", 2, 4'b0000, KLF, 2'b01, 1'b0);
      cur = 4'b0000;
      toFollow(4'b0110, 2);

      // Left: creep, dead-time, turn, done pulse, back to FOLLOW; jnc_req in CREEP ignored.
      bus.jnc_cmd = 3'b001;
      bus.jnc_req = 1'b1;
      seg("creepL", 1, 4'b0110, KFULL, 2'b10, 1'b1);
      bus.jnc_cmd = 3'b011;
      seg("creepIgnore", 3, 4'b0110, KFULL, 2'b10, 1'b1);
      bus.jnc_req = 1'b0;
      seg("creepL", CREEP - 4, 4'b0110, KFULL, 2'b10, 1'b1);
      seg("deadCreepTurn", DEAD, 4'b0000, KOFF, 2'b10, 1'b1);
      seg("turnLeft", TURN, 4'b0101, KLEFT, 2'b10, 1'b1);
      doneStep("doneLeft", 4'b0000, KOFF, 2'b01);
      seg("deadAfterLeft", DEAD - 1, 4'b0000, KOFF, 2'b01, 1'b0);
      seg("followAfterLeft", 2, 4'b0110, KLF, 2'b01, 1'b0);

      // Two BACKs toggle reverse 0->1->0, then a BACK interrupted by a collision.
      runBack(0);
      runBack(0);
      runBack(5);

      // Stop -> HOLD; stop-class command ignored; right manoeuvre ending with lf_req low -> IDLE.
      bus.jnc_cmd = 3'b100;
      bus.jnc_req = 1'b1;
      seg("hold", 1, 4'b0000, KOFF, 2'b10, 1'b1);
      bus.jnc_cmd = 3'b110;
      seg("holdIgnore", 3, 4'b0000, KOFF, 2'b10, 1'b1);
      bus.jnc_req = 1'b0;
      bus.lf_req  = 1'b0;
      seg("holdIdle", 2, 4'b0000, KOFF, 2'b10, 1'b1);
      bus.lf_req  = 1'b1;
      bus.jnc_cmd = 3'b010;
      bus.jnc_req = 1'b1;
      seg("creepR", 1, 4'b0110, KFULL, 2'b10, 1'b1);
      bus.jnc_req = 1'b0;
      seg("creepR", CREEP - 1, 4'b0110, KFULL, 2'b10, 1'b1);
      seg("deadCreepRight", DEAD, 4'b0000, KOFF, 2'b10, 1'b1);
      seg("turnRight", TURN, 4'b1010, KRIGHT, 2'b10, 1'b1);
      bus.lf_req = 1'b0;
      doneStep("doneIdle", 4'b0000, KOFF, 2'b00);
      seg("idle", 3, 4'b0000, KOFF, 2'b00, 1'b0);
      cur = 4'b0000;

      // Reset mid-turn aborts with no done pulse.
      bus.lf_req = 1'b1;
      bus.lf_dir = 4'b0110;
      seg("follow6", 2, 4'b0110, KLF, 2'b01, 1'b0);
      bus.jnc_cmd = 3'b001;
      bus.jnc_req = 1'b1;
      seg("creep6", 1, 4'b0110, KFULL, 2'b10, 1'b1);
      bus.jnc_req = 1'b0;
      seg("creep6", CREEP - 1, 4'b0110, KFULL, 2'b10, 1'b1);
      seg("dead6", DEAD, 4'b0000, KOFF, 2'b10, 1'b1);
      seg("turn6", 8, 4'b0101, KLEFT, 2'b10, 1'b1);
      rst    = 1'b1;
      expRev = 1'b0;
      seg("resetMid", 2, 4'b0000, KOFF, 2'b00, 1'b0);
      rst        = 1'b0;
      bus.lf_req = 1'b0;
      seg("postReset", TURN + 5, 4'b0000, KOFF, 2'b00, 1'b0);

      // Collision while following: enables drop, pattern held, owner 11.
      bus.lf_req = 1'b1;
      bus.lf_dir = 4'b1010;
      seg("followCol", 2, 4'b1010, KLF, 2'b01, 1'b0);
      bus.col_stop = 1'b1;
      seg("colFollow", 3, 4'b1010, KOFF, 2'b11, 1'b0);
      bus.col_stop = 1'b0;
      seg("followRelease", 2, 4'b1010, KLF, 2'b01, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
